// File: rtl/contagem_regressiva_if.sv
// Control and display bundle of the countdown timer.
// The master side is the controller; the slave side is the timer.
interface contagem_regressiva_if;
  logic [15:0] TEMPO_INICIAL;
  logic        CARREGAR;
  logic        INICIAR;
  logic        PAUSAR;
  logic        DESARMAR;
  logic [15:0] TEMPO_BCD;
  logic        TEMPO_ACABOU;
  logic        CONTANDO;
  logic        DESARMADO;

  modport master (
    output TEMPO_INICIAL, CARREGAR, INICIAR, PAUSAR, DESARMAR,
    input  TEMPO_BCD, TEMPO_ACABOU, CONTANDO, DESARMADO
  );

  modport slave (
    input  TEMPO_INICIAL, CARREGAR, INICIAR, PAUSAR, DESARMAR,
    output TEMPO_BCD, TEMPO_ACABOU, CONTANDO, DESARMADO
  );
endinterface

// File: rtl/contagem_regressiva.sv
// Bomb countdown timer: MM:SS kept in BCD, decremented once per TICKS_PER_SEC cycles.
// The bomb can be defused while counting; expiry raises TEMPO_ACABOU.
module contagem_regressiva #(
  parameter int unsigned TICKS_PER_SEC = 50_000_000
) (
  input logic                    CLOCK,
  input logic                    RESET_N,
  contagem_regressiva_if.slave   io
);

  localparam int unsigned PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [2:0] {
    ST_OCIOSO,
    ST_ARMADO,
    ST_CONTANDO,
    ST_EXPLODIDO,
    ST_DESARMADO
  } estado_t;

  estado_t       state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   tempo_q, tempo_d;
  logic          acabou_q, contando_q, desarmado_q;
  logic [15:0]   carga_c, decr_c;

  // Clamp each digit to the largest value legal in its position.
  function automatic logic [15:0] sanitize(input logic [15:0] v);
    logic [3:0] mt, mu, st, su;
    mt = (v[15:12] > 4'd9) ? 4'd9 : v[15:12];
    mu = (v[11:8]  > 4'd9) ? 4'd9 : v[11:8];
    st = (v[7:4]   > 4'd5) ? 4'd5 : v[7:4];
    su = (v[3:0]   > 4'd9) ? 4'd9 : v[3:0];
    return {mt, mu, st, su};
  endfunction

  // One-second decrement with BCD borrow through the MM:SS digits.
  function automatic logic [15:0] dec_bcd(input logic [15:0] v);
    logic [3:0] mt, mu, st, su;
    {mt, mu, st, su} = v;
    if (su != 4'd0) begin
      su = su - 4'd1;
    end else begin
      su = 4'd9;
      if (st != 4'd0) begin
        st = st - 4'd1;
      end else begin
        st = 4'd5;
        if (mu != 4'd0) begin
          mu = mu - 4'd1;
        end else begin
          mu = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    return {mt, mu, st, su};
  endfunction

  assign carga_c = sanitize(io.TEMPO_INICIAL);
  assign decr_c  = dec_bcd(tempo_q);

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_OCIOSO;
      presc_q     <= '0;
      tempo_q     <= 16'h0000;
      acabou_q    <= 1'b0;
      contando_q  <= 1'b0;
      desarmado_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      tempo_q     <= tempo_d;
      acabou_q    <= (state_d == ST_EXPLODIDO);
      contando_q  <= (state_d == ST_CONTANDO);
      desarmado_q <= (state_d == ST_DESARMADO);
    end
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    tempo_d = tempo_q;
    unique case (state_q)
      ST_OCIOSO, ST_ARMADO: begin
        if (io.CARREGAR) begin
          tempo_d = carga_c;
          state_d = (carga_c != 16'h0000) ? ST_ARMADO : ST_OCIOSO;
        end else if (state_q == ST_ARMADO && io.INICIAR) begin
          state_d = ST_CONTANDO;
          presc_d = '0;
        end
      end
      ST_CONTANDO: begin
        // Defusing wins over a coincident final tick.
        if (io.DESARMAR) begin
          state_d = ST_DESARMADO;
        end else if (!io.PAUSAR) begin
          if (presc_q == PMAX) begin
            presc_d = '0;
            tempo_d = decr_c;
            if (decr_c == 16'h0000) state_d = ST_EXPLODIDO;
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
      end
      ST_EXPLODIDO: tempo_d = 16'h0000;
      ST_DESARMADO: ;
      default: state_d = ST_OCIOSO;
    endcase
  end

  assign io.TEMPO_BCD    = tempo_q;
  assign io.TEMPO_ACABOU = acabou_q;
  assign io.CONTANDO     = contando_q;
  assign io.DESARMADO    = desarmado_q;

endmodule

// File: tb/tb_contagem_regressiva.sv
// Bench for contagem_regressiva: vector table, directed corner sequences and
// random stimulus against a seconds-based reference model.
module tb_contagem_regressiva;
  localparam int unsigned TPS = 4;
  localparam int M_IDLE = 0, M_ARMED = 1, M_RUN = 2, M_BOOM = 3, M_DEF = 4;

  logic CLOCK = 1'b0;
  logic RESET_N = 1'b0;
  int   checks = 0;
  int   errors = 0;

  int m_mode, m_secs, m_ph;

  always #5 CLOCK = ~CLOCK;

  contagem_regressiva_if io ();
  contagem_regressiva #(.TICKS_PER_SEC(TPS)) dut (
    .CLOCK  (CLOCK),
    .RESET_N(RESET_N),
    .io     (io)
  );

  typedef struct {
    logic [15:0] ti;
    logic        car, ini, pau, des;
    logic [15:0] bcd;
    logic        acabou, cont, desarm;
    string       name;
  } vec_t;

  function automatic int clamp(input int d, input int lim);
    return (d > lim) ? lim : d;
  endfunction

  // Remaining time as whole seconds after clamping each digit.
  function automatic int san_secs(input logic [15:0] v);
    int mt, mu, st, su;
    mt = clamp(int'(v[15:12]), 9);
    mu = clamp(int'(v[11:8]), 9);
    st = clamp(int'(v[7:4]), 5);
    su = clamp(int'(v[3:0]), 9);
    return (mt * 10 + mu) * 60 + st * 10 + su;
  endfunction

  function automatic logic [15:0] to_bcd(input int s);
    int m, x;
    m = s / 60;
    x = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  function automatic logic [18:0] model_out();
    return {to_bcd(m_secs), m_mode == M_BOOM, m_mode == M_RUN, m_mode == M_DEF};
  endfunction

  function automatic logic [18:0] dut_out();
    return {io.TEMPO_BCD, io.TEMPO_ACABOU, io.CONTANDO, io.DESARMADO};
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE;
    m_secs = 0;
    m_ph   = 0;
  endtask

  task automatic model_step(input logic [15:0] ti, input logic car, ini, pau, des);
    case (m_mode)
      M_IDLE, M_ARMED: begin
        if (car) begin
          m_secs = san_secs(ti);
          m_mode = (m_secs != 0) ? M_ARMED : M_IDLE;
        end else if (m_mode == M_ARMED && ini) begin
          m_mode = M_RUN;
          m_ph   = 0;
        end
      end
      M_RUN: begin
        if (des) m_mode = M_DEF;
        else if (!pau) begin
          m_ph = m_ph + 1;
          if (m_ph == TPS) begin
            m_ph   = 0;
            m_secs = m_secs - 1;
            if (m_secs == 0) m_mode = M_BOOM;
          end
        end
      end
      default: ;
    endcase
  endtask

  task automatic chk(input string nm, input logic [18:0] act, input logic [18:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got bcd=%h acabou/cont/desarm=%b expected bcd=%h acabou/cont/desarm=%b",
               nm, act[18:3], act[2:0], exp[18:3], exp[2:0]);
    end
  endtask

  // One clock: drive at the falling edge, sample just after the rising edge.
  task automatic cycle(input logic [15:0] ti, input logic car, ini, pau, des);
    @(negedge CLOCK);
    io.TEMPO_INICIAL = ti;
    io.CARREGAR = car;
    io.INICIAR  = ini;
    io.PAUSAR   = pau;
    io.DESARMAR = des;
    @(posedge CLOCK);
    model_step(ti, car, ini, pau, des);
    #1;
    chk("model", dut_out(), model_out());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rand_cycle();
    logic [15:0] ti;
    ti = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 5)) : 16'($urandom);
    cycle(ti, $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0);
  endtask

  task automatic do_reset();
    @(negedge CLOCK);
    RESET_N = 1'b0;
    io.CARREGAR = 1'b0;
    io.INICIAR  = 1'b0;
    io.PAUSAR   = 1'b0;
    io.DESARMAR = 1'b0;
    io.TEMPO_INICIAL = 16'h0000;
    model_reset();
    #1;
    chk("reset", dut_out(), 19'h0);
    @(negedge CLOCK);
    RESET_N = 1'b1;
  endtask

  task automatic load_start(input logic [15:0] t);
    cycle(t, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  vec_t vecs[17];
  logic [15:0] seq_a[4];

  initial begin
    io.TEMPO_INICIAL = 16'h0000;
    io.CARREGAR = 1'b0;
    io.INICIAR  = 1'b0;
    io.PAUSAR   = 1'b0;
    io.DESARMAR = 1'b0;
    model_reset();
    #12;
    chk("reset_initial", dut_out(), 19'h0);
    @(negedge CLOCK);
    RESET_N = 1'b1;

    vecs[0]  = '{16'h0000, 0, 0, 0, 1, 16'h0000, 0, 0, 0, "des_idle"};
    vecs[1]  = '{16'hAB7C, 1, 0, 0, 0, 16'h9959, 0, 0, 0, "load_sanit"};
    vecs[2]  = '{16'h0000, 1, 0, 0, 0, 16'h0000, 0, 0, 0, "load_zero"};
    vecs[3]  = '{16'h0000, 0, 1, 0, 0, 16'h0000, 0, 0, 0, "ini_in_idle"};
    vecs[4]  = '{16'h0002, 1, 1, 0, 0, 16'h0002, 0, 0, 0, "car_over_ini"};
    vecs[5]  = '{16'h0000, 0, 1, 0, 0, 16'h0002, 0, 1, 0, "start"};
    vecs[6]  = '{16'h0000, 0, 0, 0, 0, 16'h0002, 0, 1, 0, "count1"};
    vecs[7]  = '{16'h0000, 0, 0, 0, 0, 16'h0002, 0, 1, 0, "count2"};
    vecs[8]  = '{16'h0000, 0, 0, 0, 0, 16'h0002, 0, 1, 0, "count3"};
    vecs[9]  = '{16'h0000, 0, 0, 0, 0, 16'h0001, 0, 1, 0, "tick1"};
    vecs[10] = '{16'h0500, 1, 0, 0, 0, 16'h0001, 0, 1, 0, "car_ignored"};
    vecs[11] = '{16'h0000, 0, 1, 0, 0, 16'h0001, 0, 1, 0, "ini_ignored"};
    vecs[12] = '{16'h0000, 0, 0, 1, 0, 16'h0001, 0, 1, 0, "paused"};
    vecs[13] = '{16'h0000, 0, 0, 0, 0, 16'h0001, 0, 1, 0, "count_pre"};
    vecs[14] = '{16'h0000, 0, 0, 0, 0, 16'h0000, 1, 0, 0, "boom"};
    vecs[15] = '{16'h0000, 0, 0, 0, 1, 16'h0000, 1, 0, 0, "boom_des"};
    vecs[16] = '{16'h0300, 1, 1, 0, 0, 16'h0000, 1, 0, 0, "boom_car"};
    for (int i = 0; i < 17; i++) begin
      cycle(vecs[i].ti, vecs[i].car, vecs[i].ini, vecs[i].pau, vecs[i].des);
      chk({"tbl_", vecs[i].name}, dut_out(),
          {vecs[i].bcd, vecs[i].acabou, vecs[i].cont, vecs[i].desarm});
    end

    // Borrow from minutes into seconds.
    seq_a[0] = 16'h0102; seq_a[1] = 16'h0101; seq_a[2] = 16'h0100; seq_a[3] = 16'h0059;
    do_reset();
    load_start(16'h0103);
    for (int i = 1; i <= 16; i++) begin
      idle(1);
      if (i % 4 == 0) chk("borrow_step", dut_out(), {seq_a[i/4 - 1], 3'b010});
    end

    // Expiry and hold.
    do_reset();
    load_start(16'h0002);
    idle(4);
    chk("expiry_0001", dut_out(), {16'h0001, 3'b010});
    idle(4);
    chk("expiry_0000", dut_out(), {16'h0000, 3'b100});
    for (int i = 0; i < 100; i++) rand_cycle();
    chk("expiry_held", dut_out(), {16'h0000, 3'b100});

    // Defuse on the same cycle as the final tick.
    do_reset();
    load_start(16'h0001);
    idle(3);
    cycle(16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("defuse_final", dut_out(), {16'h0001, 3'b001});
    for (int i = 0; i < 20; i++) rand_cycle();
    chk("defuse_held", dut_out(), {16'h0001, 3'b001});

    // Pause delays the tick by exactly its length.
    do_reset();
    load_start(16'h0005);
    idle(2);
    for (int i = 0; i < 10; i++) cycle(16'h0900, i == 4, 1'b0, 1'b1, 1'b0);
    chk("pause_load_ign", dut_out(), {16'h0005, 3'b010});
    idle(1);
    chk("pause_pretick", dut_out(), {16'h0005, 3'b010});
    idle(1);
    chk("pause_tick", dut_out(), {16'h0004, 3'b010});

    // Asynchronous reset between edges while counting.
    do_reset();
    load_start(16'h0010);
    idle(2);
    #1 RESET_N = 1'b0;
    #1;
    model_reset();
    chk("async_reset", dut_out(), 19'h0);
    @(negedge CLOCK);
    RESET_N = 1'b1;
    cycle(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("ini_after_reset", dut_out(), 19'h0);

    // Random traffic with periodic resets.
    for (int i = 0; i < 600; i++) begin
      if (i % 75 == 0) do_reset();
      rand_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
